// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU issue/response stage.
// Command and response bundles travel through the FIFOs as packed structs.
package alu_pkg;

   localparam int OPCODE_WIDTH = 2;
   localparam int DATA_WIDTH   = 61;
   localparam int TAG_WIDTH    = 4;

   typedef enum logic [OPCODE_WIDTH:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_INC = 3'd2,
      OP_DEC = 3'd3
   } alu_op_e;

   typedef struct packed {
      logic [OPCODE_WIDTH:0] opcode;
      logic [DATA_WIDTH:0]   op1;
      logic [DATA_WIDTH:0]   op2;
      logic [TAG_WIDTH-1:0]  tag;
   } alu_cmd_t;

   typedef struct packed {
      logic [DATA_WIDTH:0]  result;
      logic                 carry;
      logic                 zero;
      logic [TAG_WIDTH-1:0] tag;
      logic                 err;
   } alu_rsp_t;

   function automatic logic op_unsupported(
      input logic [OPCODE_WIDTH:0] op
   );
      return op > OP_DEC;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO, synchronous active-high reset.
// Push on full and pop on empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push)
            wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
         if (do_pop)
            rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wptr] <= wdata;
   end

endmodule

// File: rtl/alu_issue_q.sv
// Issue queue around the alu: buffers tagged commands, issues them on credit,
// and collects registered alu results into an in-order response FIFO.
module alu_issue_q #(
   parameter int OPCODE_WIDTH = 2,
   parameter int DATA_WIDTH   = 61,
   parameter int TAG_WIDTH    = 4,
   parameter int CMD_DEPTH    = 4,
   parameter int RSP_DEPTH    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [OPCODE_WIDTH:0]   cmd_opcode,
   input  logic [DATA_WIDTH:0]     cmd_op1,
   input  logic [DATA_WIDTH:0]     cmd_op2,
   input  logic [TAG_WIDTH-1:0]    cmd_tag,
   output logic [OPCODE_WIDTH:0]   alu_opcode,
   output logic [DATA_WIDTH:0]     alu_op1,
   output logic [DATA_WIDTH:0]     alu_op2,
   input  logic [DATA_WIDTH:0]     alu_result,
   input  logic                    alu_carry,
   input  logic                    alu_zero,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH:0]     rsp_result,
   output logic                    rsp_carry,
   output logic                    rsp_zero,
   output logic [TAG_WIDTH-1:0]    rsp_tag,
   output logic                    rsp_err,
   output logic                    busy
);

   import alu_pkg::*;

   localparam int CRW = $clog2(RSP_DEPTH + 1);
   localparam logic [CRW-1:0] CR_MAX = CRW'(RSP_DEPTH);

   alu_cmd_t             cmd_wdata;
   alu_cmd_t             cmd_head;
   alu_rsp_t             rsp_wdata;
   alu_rsp_t             rsp_head;
   logic                 cmd_full;
   logic                 cmd_empty;
   logic                 rsp_full;
   logic                 rsp_empty;
   logic                 issue;
   logic                 rsp_pop;
   logic                 inflight;
   logic [CRW-1:0]       credits;
   logic [TAG_WIDTH-1:0] fl_tag;
   logic                 fl_err;

   assign cmd_ready = !cmd_full;
   assign cmd_wdata = {cmd_opcode, cmd_op1, cmd_op2, cmd_tag};

   sync_fifo #(
      .WIDTH ($bits(alu_cmd_t)),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid && cmd_ready),
      .wdata (cmd_wdata),
      .pop   (issue),
      .rdata (cmd_head),
      .full  (cmd_full),
      .empty (cmd_empty)
   );

   // A credit reserves a response slot, so the alu result always fits.
   assign issue      = !cmd_empty && (credits != '0);
   assign alu_opcode = issue ? cmd_head.opcode : '0;
   assign alu_op1    = issue ? cmd_head.op1 : '0;
   assign alu_op2    = issue ? cmd_head.op2 : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= 1'b0;
         fl_tag   <= '0;
         fl_err   <= 1'b0;
         credits  <= CR_MAX;
      end else begin
         inflight <= issue;
         if (issue) begin
            fl_tag <= cmd_head.tag;
            fl_err <= op_unsupported(cmd_head.opcode);
         end
         unique case ({issue, rsp_pop})
            2'b10:   credits <= credits - 1'b1;
            2'b01:   credits <= credits + 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   assign rsp_wdata = {alu_result, alu_carry, alu_zero, fl_tag, fl_err};

   sync_fifo #(
      .WIDTH ($bits(alu_rsp_t)),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .wdata (rsp_wdata),
      .pop   (rsp_pop),
      .rdata (rsp_head),
      .full  (rsp_full),
      .empty (rsp_empty)
   );

   assign rsp_valid  = !rsp_empty;
   assign rsp_pop    = rsp_valid && rsp_ready;
   assign rsp_result = rsp_valid ? rsp_head.result : '0;
   assign rsp_carry  = rsp_valid && rsp_head.carry;
   assign rsp_zero   = rsp_valid && rsp_head.zero;
   assign rsp_tag    = rsp_valid ? rsp_head.tag : '0;
   assign rsp_err    = rsp_valid && rsp_head.err;

   assign busy = !cmd_empty || inflight || !rsp_empty;

   a_credit_max: assert property (@(posedge clk) disable iff (rst)
      credits <= CR_MAX);
   a_credit_min: assert property (@(posedge clk) disable iff (rst)
      !(rsp_pop && !issue && credits == CR_MAX));
   a_no_drop: assert property (@(posedge clk) disable iff (rst)
      !(inflight && rsp_full));

endmodule

// File: tb/tb_alu_issue_q.sv
// Scoreboard bench for alu_issue_q with a registered alu stand-in.
// Expected responses come from an integer model of the alu rules.
module tb_alu_issue_q;

   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_opcode = '0;
   logic [61:0] cmd_op1 = '0;
   logic [61:0] cmd_op2 = '0;
   logic [3:0]  cmd_tag = '0;
   logic [2:0]  alu_opcode;
   logic [61:0] alu_op1;
   logic [61:0] alu_op2;
   logic [61:0] alu_result;
   logic        alu_carry;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [61:0] rsp_result;
   logic        rsp_carry;
   logic        rsp_zero;
   logic [3:0]  rsp_tag;
   logic        rsp_err;
   logic        busy;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int nrsp = 0;
   bit rnd_rdy = 1'b0;
   alu_rsp_t sb[$];
   int rsp_cyc[$];
   alu_rsp_t last_rsp;
   alu_rsp_t mon_got;
   alu_rsp_t mon_exp;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_issue_q #(
      .CMD_DEPTH (4),
      .RSP_DEPTH (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_opcode (cmd_opcode),
      .cmd_op1    (cmd_op1),
      .cmd_op2    (cmd_op2),
      .cmd_tag    (cmd_tag),
      .alu_opcode (alu_opcode),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_result (alu_result),
      .alu_carry  (alu_carry),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_carry  (rsp_carry),
      .rsp_zero   (rsp_zero),
      .rsp_tag    (rsp_tag),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   // Registered alu stand-in: adder with inverted operand for subtraction.
   function automatic logic [63:0] alu_fn(
      input logic [2:0] op, input logic [61:0] a, input logic [61:0] b);
      logic [62:0] s;
      logic        c;
      s = '0;
      c = 1'b0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; c = s[62]; end
         3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 63'd1; c = ~s[62]; end
         3'd2: begin s = {1'b0, a} + 63'd1; c = s[62]; end
         3'd3: begin s = {1'b0, a} + {1'b0, {62{1'b1}}}; c = ~s[62]; end
         default: begin s = '0; c = 1'b0; end
      endcase
      return {s[61:0], c, s[61:0] == 62'd0};
   endfunction

   always @(posedge clk) begin
      if (rst)
         {alu_result, alu_carry, alu_zero} <= '0;
      else
         {alu_result, alu_carry, alu_zero} <=
            alu_fn(alu_opcode, alu_op1, alu_op2);
   end

   function automatic alu_rsp_t ref_rsp(input logic [2:0] op,
      input logic [61:0] a, input logic [61:0] b, input logic [3:0] tag);
      longint unsigned x, z, r, m;
      bit c, e;
      alu_rsp_t o;
      m = 64'h4000_0000_0000_0000;
      x = 64'(a);
      z = 64'(b);
      r = 0;
      c = 1'b0;
      e = 1'b0;
      case (op)
         3'd0: begin r = x + z; c = (r >= m); end
         3'd1: begin r = x - z; c = (x < z); end
         3'd2: begin r = x + 1; c = (r >= m); end
         3'd3: begin r = x - 1; c = (x == 0); end
         default: e = 1'b1;
      endcase
      r = r % m;
      o.result = r[61:0];
      o.carry  = c;
      o.zero   = (r == 0);
      o.tag    = tag;
      o.err    = e;
      return o;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act,
      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s act=timeout exp=event", nm);
   endtask

   // Monitor: pops the scoreboard on every response handshake.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         mon_got = {rsp_result, rsp_carry, rsp_zero, rsp_tag, rsp_err};
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected act=%0h exp=none", mon_got);
         end else begin
            mon_exp = sb.pop_front();
            chk("rsp", mon_got, mon_exp);
         end
         last_rsp = mon_got;
         nrsp++;
         rsp_cyc.push_back(cyc);
      end
   end

   function automatic logic [61:0] rnd62();
      logic [63:0] w;
      w = {$urandom, $urandom};
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 62'd1;
         default: return w[61:0];
      endcase
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic try_send(input logic [2:0] op, input logic [61:0] a,
      input logic [61:0] b, input logic [3:0] tag, input int tmo,
      output bit ok);
      bit got;
      got = 1'b0;
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_op1    = a;
      cmd_op2    = b;
      cmd_tag    = tag;
      for (int i = 0; i < tmo && !got; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            got = 1'b1;
            hs_cyc = cyc;
            sb.push_back(ref_rsp(op, a, b, tag));
         end
         @(posedge clk);
         #1;
         if (rnd_rdy)
            rsp_ready = ($urandom_range(0, 3) != 0);
      end
      cmd_valid = 1'b0;
      ok = got;
   endtask

   task automatic send(input logic [2:0] op, input logic [61:0] a,
      input logic [61:0] b, input logic [3:0] tag);
      bit ok;
      try_send(op, a, b, tag, 100, ok);
      if (!ok)
         fail_now("send");
   endtask

   task automatic send_wait(input logic [2:0] op, input logic [61:0] a,
      input logic [61:0] b, input logic [3:0] tag);
      int n0;
      n0 = nrsp;
      send(op, a, b, tag);
      for (int i = 0; i < 20 && nrsp == n0; i++)
         wait_cyc(1);
      if (nrsp == n0)
         fail_now("rsp_wait");
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 300 && (sb.size() != 0 || busy); i++)
         wait_cyc(1);
      if (i == 300)
         fail_now("drain");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int acc;
      bit ok;
      logic [66:0] held;
      wait_cyc(2);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_opcode", {alu_opcode, alu_op1, alu_op2}, 0);
      chk("rst_rsp_data", {rsp_result, rsp_carry, rsp_zero, rsp_tag,
         rsp_err}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rsp_ready = 1'b1;

      send(3'd0, 62'd5, 62'd7, 4'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      chk("latency", 32'(cyc - hs_cyc), 3);
      wait_cyc(1);
      chk("add_5_7", last_rsp, {62'd12, 1'b0, 1'b0, 4'd1, 1'b0});

      send_wait(3'd1, 62'd0, 62'd1, 4'd2);
      chk("sub_0_1", last_rsp, {62'h3FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
         4'd2, 1'b0});
      send_wait(3'd0, 62'd0, 62'd0, 4'd3);
      chk("add_0_0", last_rsp, {62'd0, 1'b0, 1'b1, 4'd3, 1'b0});

      n0 = rsp_cyc.size();
      for (int i = 1; i <= 8; i++)
         send(3'd2, 62'(i), 62'd0, 4'(i));
      drain();
      chk("b2b_count", 32'(rsp_cyc.size() - n0), 8);
      chk("b2b_pair", 32'(rsp_cyc[n0 + 1] - rsp_cyc[n0]), 1);
      chk("b2b_span_ok", 32'(rsp_cyc[n0 + 7] - rsp_cyc[n0] <= 12), 1);
      chk("b2b_last", last_rsp, {62'd9, 1'b0, 1'b0, 4'd8, 1'b0});

      rsp_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         if (acc == i) begin
            try_send(3'd0, 62'(i), 62'd100, 4'(8 + i), 6, ok);
            if (ok) acc++;
         end
      end
      chk("bp_accepted", 32'(acc), 6);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_pending", 32'(sb.size()), 6);
      held = {rsp_result, rsp_tag, rsp_valid};
      wait_cyc(3);
      chk("bp_hold", {rsp_result, rsp_tag, rsp_valid}, held);
      rsp_ready = 1'b1;
      for (int i = acc; i < 8; i++)
         send(3'd0, 62'(i), 62'd100, 4'(8 + i));
      drain();
      chk("bp_last", last_rsp, {62'd107, 1'b0, 1'b0, 4'd15, 1'b0});

      send_wait(3'd5, 62'd9, 62'd0, 4'd4);
      chk("unsup_5", last_rsp, {62'd0, 1'b0, 1'b1, 4'd4, 1'b1});
      send_wait(3'd3, 62'd0, 62'd0, 4'd5);
      chk("dec_0", last_rsp, {62'h3FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
         4'd5, 1'b0});

      rnd_rdy = 1'b1;
      for (int i = 0; i < 60; i++)
         send(3'($urandom_range(0, 7)), rnd62(), rnd62(),
            4'($urandom_range(0, 15)));
      rnd_rdy = 1'b0;
      rsp_ready = 1'b1;
      drain();
      chk("rand_sb_empty", 32'(sb.size()), 0);

      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(3'd2, 62'(i), 62'd0, 4'(i));
      wait_cyc(4);
      chk("pre_rst_unread", rsp_valid, 1);
      rst = 1'b1;
      wait_cyc(1);
      rst = 1'b0;
      sb.delete();
      n0 = nrsp;
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_busy", busy, 0);
      rsp_ready = 1'b1;
      wait_cyc(10);
      chk("mid_rst_no_stale", 32'(nrsp - n0), 0);

      send_wait(3'd0, 62'h3FFF_FFFF_FFFF_FFFF, 62'd1, 4'd9);
      chk("add_carry_out", last_rsp, {62'd0, 1'b1, 1'b1, 4'd9, 1'b0});
      drain();
      chk("final_sb_empty", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
